// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: iterative AES-128 key expansion, one round key per accepted handshake.
// Latency: first key is valid the cycle after i_start; next key the cycle after each accept.
// Backpressure: o_rk/o_rk_idx hold while i_rk_ready is low; nothing advances without an accept.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   i_start, i_key    start request (honoured in IDLE only) and 128-bit cipher key
//   o_busy            high whenever an expansion is in progress (EMIT or DONE)
//   o_rk_valid/_ready round-key handshake; o_rk is the key, o_rk_idx its round index
//   o_done            one-cycle pulse after the final key is accepted
// Optional macro KEY_SCHED_STORE_EN adds an 11-entry round-key store:
//   i_rd_idx, o_rd_key (combinational read), o_store_valid (full schedule present).

// Four AES S-boxes applied bytewise to a 32-bit word.
// S-box = GF(2^8) inverse (x^254) followed by the AES affine transform.
module sub_word (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    o_word = '0;
    for (int i = 0; i < 4; i++) begin
      o_word[8*i +: 8] = sbox(i_word[8*i +: 8]);
    end
  end

endmodule

module key_sched_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [127:0]   i_key,
  output logic           o_busy,
  output logic           o_rk_valid,
  input  logic           i_rk_ready,
  output logic [127:0]   o_rk,
  output logic [3:0]     o_rk_idx,
`ifdef KEY_SCHED_STORE_EN
  input  logic [3:0]     i_rd_idx,
  output logic [127:0]   o_rd_key,
  output logic           o_store_valid,
`endif
  output logic           o_done
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   cur_key_q, cur_key_d;
  logic [3:0]     round_q, round_d;
  logic [7:0]     rcon_q, rcon_d;

  logic           accept;
  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    rot_w, sub_w, temp_w;
  logic [31:0]    n0, n1, n2, n3;
  logic [127:0]   next_key;

  // Single shared S-box bank, fed from the registered key so timing stays one level deep.
  sub_word u_sub_word (
    .i_word (rot_w),
    .o_word (sub_w)
  );

  always_comb begin
    w0     = cur_key_q[127:96];
    w1     = cur_key_q[95:64];
    w2     = cur_key_q[63:32];
    w3     = cur_key_q[31:0];
    rot_w  = {w3[23:0], w3[31:24]};
    temp_w = sub_w ^ {rcon_q, 24'h0};
    n0     = w0 ^ temp_w;
    n1     = w1 ^ n0;
    n2     = w2 ^ n1;
    n3     = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  assign accept = (state_q == EMIT) && i_rk_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_key_q <= '0;
      round_q   <= '0;
      rcon_q    <= 8'h01;
    end else begin
      state_q   <= state_d;
      cur_key_q <= cur_key_d;
      round_q   <= round_d;
      rcon_q    <= rcon_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_key_d  = cur_key_q;
    round_d    = round_q;
    rcon_d     = rcon_q;
    o_busy     = 1'b0;
    o_rk_valid = 1'b0;
    o_rk       = '0;
    o_rk_idx   = '0;
    o_done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          cur_key_d = i_key;
          round_d   = '0;
          rcon_d    = 8'h01;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        o_busy     = 1'b1;
        o_rk_valid = 1'b1;
        o_rk       = cur_key_q;
        o_rk_idx   = round_q;
        if (accept) begin
          if (round_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            cur_key_d = next_key;
            round_d   = round_q + 4'd1;
            rcon_d    = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          end
        end
      end
      DONE: begin
        o_busy  = 1'b1;
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef KEY_SCHED_STORE_EN
  logic [127:0] store_q [0:10];
  logic         store_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) store_q[i] <= '0;
      store_valid_q <= 1'b0;
    end else begin
      if (accept) store_q[round_q] <= cur_key_q;
      if (state_q == DONE) begin
        store_valid_q <= 1'b1;
      end else if (state_q == IDLE && i_start) begin
        store_valid_q <= 1'b0;
      end
    end
  end

  assign o_rd_key      = (i_rd_idx > LAST_IDX) ? '0 : store_q[i_rd_idx];
  assign o_store_valid = store_valid_q;
`endif

endmodule
